burst_mem_responder: RTL and testbench

Physical-memory responder for the 64-bit burst interface driven by `cacheline_adaptor` on the memory side of `mp4`. It accepts line-aligned read and write requests and services each one as a four-beat burst after a programmable latency. It stores whole 256-bit lines internally and is the synthesizable far end of `mem_read`/`mem_write`/`mem_resp`. It is used as the memory model in system benches and in FPGA bring-up.

---
 rtl/burst_mem_responder.sv | 112 +++++++++++
 tb/tb_burst_mem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Line-granular memory responder for a 64-bit, four-beat burst interface.
// Requests wait LATENCY cycles, stream four quadwords, then take one idle slot.
module burst_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        proto_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] { IDLE, WAIT, BURST, DONE } state_t;

  state_t                state;
  logic [CNT_W-1:0]      lat_cnt;
  logic [1:0]            beat;
  logic [1:0]            beat_nx;
  logic                  op_rd;
  logic [ADDR_WIDTH-1:0] line_idx;
  logic                  req_any;
  logic                  req_held;
  logic                  burst_start;
  logic                  commit;
  logic [255:0]          line_buf;
  logic [255:0]          storage [DEPTH];
  logic                  unused_addr;

  assign req_any     = mem_read | mem_write;
  assign req_held    = op_rd ? mem_read : mem_write;
  assign burst_start = (state == WAIT) && req_held && (lat_cnt == '0);
  assign commit      = (state == BURST) && !op_rd && (beat == 2'd3);
  assign beat_nx     = beat + 2'd1;
  assign unused_addr = ^{mem_address[31:ADDR_WIDTH+5], mem_address[4:0]};

  // Control and registered outputs; DONE's closing edge samples requests like IDLE,
  // so an initiator that drops its request during DONE is not re-accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      beat      <= '0;
      op_rd     <= 1'b0;
      line_idx  <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          mem_resp  <= 1'b0;
          mem_rdata <= '0;
          if (req_any) begin
            state    <= WAIT;
            op_rd    <= mem_read;
            line_idx <= mem_address[ADDR_WIDTH+4:5];
            lat_cnt  <= CNT_LOAD;
            if (mem_read && mem_write)
              proto_err <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!req_held) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            state     <= BURST;
            beat      <= '0;
            mem_resp  <= 1'b1;
            mem_rdata <= op_rd ? storage[line_idx][63:0] : '0;
          end else begin
            lat_cnt <= lat_cnt - CNT_ONE;
          end
        end
        BURST: begin
          beat <= beat_nx;
          if (beat == 2'd3) begin
            state     <= DONE;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
          end else begin
            mem_rdata <= op_rd ? line_buf[{beat_nx, 6'd0} +: 64] : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffer and storage carry data only; a reset simply leaves them untouched,
  // and the write commit is gated by the (reset) control state.
  always_ff @(posedge clk) begin
    if (burst_start && op_rd)
      line_buf <= storage[line_idx];
    else if ((state == BURST) && !op_rd)
      line_buf[{beat, 6'd0} +: 64] <= mem_wdata;
    if (commit)
      storage[line_idx] <= {mem_wdata, line_buf[191:0]};
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: directed scenarios with literal expectations plus
// a randomized stream checked every cycle against a timeline model of the protocol.
module tb_burst_mem_responder;

  localparam int LAT = 4;
  localparam int NE  = 16384;

  logic        clk;
  logic        reset_n;
  logic        rd_i    [3];
  logic        wr_i    [3];
  logic [31:0] addr_i  [3];
  logic [63:0] wdata_i [3];
  logic        resp_o  [3];
  logic [63:0] rdata_o [3];
  logic        perr_o  [3];

  int checks   = 0;
  int failures = 0;

  burst_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut0 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
    .mem_address(addr_i[0]), .mem_wdata(wdata_i[0]), .mem_resp(resp_o[0]),
    .mem_rdata(rdata_o[0]), .proto_err(perr_o[0]));

  burst_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
    .mem_address(addr_i[1]), .mem_wdata(wdata_i[1]), .mem_resp(resp_o[1]),
    .mem_rdata(rdata_o[1]), .proto_err(perr_o[1]));

  burst_mem_responder #(.ADDR_WIDTH(8), .LATENCY(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd_i[2]), .mem_write(wr_i[2]),
    .mem_address(addr_i[2]), .mem_wdata(wdata_i[2]), .mem_resp(resp_o[2]),
    .mem_rdata(rdata_o[2]), .proto_err(perr_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle expected outputs laid out on a timeline.
  int        ecnt;
  bit        exp_resp [NE];
  bit        exp_dchk [NE];
  bit [63:0] exp_data [NE];
  bit        exp_perr;
  bit        m_act, m_rd;
  int        m_acc, m_rel;
  int        m_idx;
  bit [63:0] m_st [4];
  bit [255:0] mline [256];
  bit        mknown [256];

  initial begin
    ecnt = 0; m_act = 0; exp_perr = 0; m_acc = 0; m_rel = 0; m_idx = 0; m_rd = 0;
    forever begin
      @(posedge clk);
      ecnt++;
      if (!reset_n) begin
        m_act = 0;
        exp_perr = 0;
      end else if (m_act) begin
        m_rel = ecnt - m_acc;
        if (m_rel <= LAT) begin
          if (!(m_rd ? rd_i[0] : wr_i[0])) m_act = 0;
          else if (m_rel == LAT) begin
            for (int k = 0; k < 4; k++) begin
              if (ecnt + k < NE) begin
                exp_resp[ecnt+k] = 1'b1;
                exp_dchk[ecnt+k] = m_rd && mknown[m_idx];
                exp_data[ecnt+k] = mline[m_idx][64*k +: 64];
              end
            end
          end
        end else begin
          if (!m_rd) m_st[m_rel-LAT-1] = wdata_i[0];
          if (m_rel == LAT + 4) begin
            if (!m_rd) begin
              mline[m_idx]  = {m_st[3], m_st[2], m_st[1], m_st[0]};
              mknown[m_idx] = 1'b1;
            end
            m_act = 0;
          end
        end
      end else if (rd_i[0] || wr_i[0]) begin
        m_act = 1;
        m_acc = ecnt;
        m_rd  = rd_i[0];
        m_idx = int'(addr_i[0][12:5]);
        if (rd_i[0] && wr_i[0]) exp_perr = 1'b1;
      end
    end
  end

  task automatic model_reset();
    m_act = 0;
    exp_perr = 0;
    for (int c = ecnt; c < ecnt + 16 && c < NE; c++) begin
      exp_resp[c] = 0; exp_dchk[c] = 0; exp_data[c] = '0;
    end
  endtask

  // Every-cycle compare of the main instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (ecnt > 0 && ecnt < NE) begin
        chk("resp", resp_o[0], exp_resp[ecnt]);
        if (!exp_resp[ecnt] || exp_dchk[ecnt]) chk("rdata", rdata_o[0], exp_data[ecnt]);
        chk("proto_err", perr_o[0], exp_perr);
      end
    end
  end

  task automatic run_burst(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] line, output logic [255:0] got,
                           output int lat, output int len);
    int k, guard, acc;
    bit gap;
    k = 0; guard = 0; lat = -1; len = 0; got = '0; gap = 0;
    @(negedge clk);
    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = addr; wdata_i[d] = line[63:0];
    @(posedge clk);
    #1 acc = ecnt;
    while (k < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (resp_o[d]) begin
        if (k == 0) lat = ecnt - acc;
        wdata_i[d] = line[64*k +: 64];
        got[64*k +: 64] = rdata_o[d];
        k++;
      end else if (k > 0) begin
        gap = 1;
      end
    end
    @(negedge clk);
    if (k == 4 && !gap) len = resp_o[d] ? 5 : 4;
    else len = -k;
    rd_i[d] = 0; wr_i[d] = 0;
  endtask

  task automatic abort_req(input bit rd, input logic [31:0] addr, input int j);
    @(negedge clk);
    rd_i[0] = rd; wr_i[0] = !rd; addr_i[0] = addr;
    repeat (j + 1) @(negedge clk);
    rd_i[0] = 0; wr_i[0] = 0;
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [255:0] got, la, lb, lc, lw, ls;
    logic [31:0]  addr;
    int lat, len, cnt, k, guard, n, hi, nrun, op, idx;
    bit r [48];
    int rstart [4];
    int rlen [4];

    la = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
    lb = {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000};
    lc = {64'hCCCC_0003_0003_0003, 64'hCCCC_0002_0002_0002, 64'hCCCC_0001_0001_0001, 64'hCCCC_0000_0000_0000};
    lw = {64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_CAFE_F00D};
    ls = {64'h7777_7777_0000_0003, 64'h7777_7777_0000_0002, 64'h7777_7777_0000_0001, 64'h7777_7777_0000_0000};

    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rd_i[d] = 0; wr_i[d] = 0; addr_i[d] = '0; wdata_i[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_resp", resp_o[d], 0);
      chk("reset_rdata", rdata_o[d], 0);
      chk("reset_proto_err", perr_o[d], 0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read line at 0x40
    run_burst(0, 0, 1, 32'h0000_0040,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, got, lat, len);
    chk("wr_latency", lat, 4);
    chk("wr_burst_len", len, 4);
    run_burst(0, 1, 0, 32'h0000_0040, '0, got, lat, len);
    chk("rd_latency", lat, 4);
    chk("rd_burst_len", len, 4);
    chk("rd_beats", got, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Back-to-back reads with the request held through DONE
    for (int i = 0; i < 48; i++) r[i] = 0;
    for (int i = 0; i < 4; i++) begin rstart[i] = 0; rlen[i] = 0; end
    @(negedge clk);
    rd_i[0] = 1; addr_i[0] = 32'h0000_0080;
    hi = 0; n = 0;
    while (hi < 8 && n < 40) begin
      @(negedge clk);
      r[n] = resp_o[0];
      if (resp_o[0]) hi++;
      n++;
    end
    @(negedge clk);
    r[n] = resp_o[0];
    n++;
    rd_i[0] = 0;
    nrun = 0;
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        if (i == 0 || !r[i-1]) begin
          if (nrun < 4) rstart[nrun] = i;
          nrun++;
        end
        if (nrun <= 4) rlen[nrun-1]++;
      end
    end
    chk("b2b_bursts", nrun, 2);
    chk("b2b_len0", rlen[0], 4);
    chk("b2b_len1", rlen[1], 4);
    chk("b2b_spacing", rstart[1] - rstart[0], 9);

    run_burst(0, 0, 1, 32'h0000_00A0, lw, got, lat, len);
    run_burst(0, 1, 0, 32'h0000_00A0, '0, got, lat, len);
    chk("wr_rd_same_line", got, lw);

    // Aliasing: 0x2040 and 0x5F both map to line 2
    run_burst(0, 0, 1, 32'h0000_2040, lc, got, lat, len);
    run_burst(0, 1, 0, 32'h0000_005F, '0, got, lat, len);
    chk("alias_data", got, lc);

    // Abort during WAIT, then a normal request
    abort_req(1, 32'h0000_0040, 1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_o[0]) cnt++;
    end
    chk("abort_no_resp", cnt, 0);
    run_burst(0, 1, 0, 32'h0000_0040, '0, got, lat, len);
    chk("after_abort_latency", lat, 4);
    chk("after_abort_data", got, lc);

    // Read and write together: read wins, error is sticky
    run_burst(0, 1, 1, 32'h0000_0040, lw, got, lat, len);
    chk("proto_err_set", perr_o[0], 1);
    chk("proto_err_read_data", got, lc);
    run_burst(0, 1, 0, 32'h0000_00A0, '0, got, lat, len);
    chk("proto_err_sticky", perr_o[0], 1);

    // Reset in the middle of a write burst
    run_burst(0, 0, 1, 32'h0000_0060, la, got, lat, len);
    @(negedge clk);
    wr_i[0] = 1; addr_i[0] = 32'h0000_0060; wdata_i[0] = lb[63:0];
    k = 0; guard = 0;
    while (k < 3 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (resp_o[0]) begin
        wdata_i[0] = lb[64*k +: 64];
        k++;
      end
    end
    chk("midwrite_beats_seen", k, 3);
    @(posedge clk);
    #2;
    model_reset();
    reset_n = 1'b0;
    #1;
    chk("async_reset_resp", resp_o[0], 0);
    chk("async_reset_rdata", rdata_o[0], 0);
    chk("async_reset_proto_err", perr_o[0], 0);
    wr_i[0] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_burst(0, 1, 0, 32'h0000_0060, '0, got, lat, len);
    chk("reset_keeps_line", got, la);

    // Latency sweep on the LATENCY=1 and LATENCY=7 instances
    run_burst(1, 0, 1, 32'h0000_0040, ls, got, lat, len);
    chk("lat1_wr_latency", lat, 1);
    chk("lat1_wr_len", len, 4);
    run_burst(1, 1, 0, 32'h0000_0040, '0, got, lat, len);
    chk("lat1_rd_latency", lat, 1);
    chk("lat1_rd_data", got, ls);
    run_burst(2, 0, 1, 32'h0000_0040, ls, got, lat, len);
    chk("lat7_wr_latency", lat, 7);
    chk("lat7_wr_len", len, 4);
    run_burst(2, 1, 0, 32'h0000_0040, '0, got, lat, len);
    chk("lat7_rd_latency", lat, 7);
    chk("lat7_rd_data", got, ls);

    // Randomized stream over 16 lines with aliased upper bits and junk low bits
    for (int i = 0; i < 16; i++)
      run_burst(0, 0, 1, 32'(i << 5), rand_line(), got, lat, len);
    for (int t = 0; t < 200; t++) begin
      idx  = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFFF_E000) | 32'(idx << 5) | 32'($urandom_range(0, 31));
      op   = $urandom_range(0, 99);
      if (op < 45)      run_burst(0, 1, 0, addr, '0, got, lat, len);
      else if (op < 85) run_burst(0, 0, 1, addr, rand_line(), got, lat, len);
      else if (op < 93) abort_req(bit'($urandom_range(0, 1)), addr, $urandom_range(0, LAT - 1));
      else              run_burst(0, 1, 1, addr, rand_line(), got, lat, len);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
